l2_cache_control_nway: RTL
==========================

# l2_cache_control_nway

Parametrised set-associative L2 cache controller FSM, the successor to the fixed 4-way L2 controller. It sits between the L1 arbiter (mem_* side) and physical memory (pmem_* side). It drives the tag, data, valid and dirty arrays and the tree pseudo-LRU array of a WAYS-way, SETS-set L2 datapath. Compared with the 4-way controller it adds:
- synchronous reset;
- invalid-way-first victim selection;
- a registered victim;
- a whole-cache write-back flush walker.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, 2..8. W = log2(WAYS).
- SETS, 8, number of sets; power of two, ≥2. S = log2(SETS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_read, mem_write  in  1 each  upstream request strobes, held until mem_resp.
- mem_resp  out  1  request complete.
- flush_req  in  1  level request to write back every dirty line.
- flush_done  out  1  one-cycle pulse when the flush finishes.
- pmem_read, pmem_write  out  1 each  memory request, held until pmem_resp.
- pmem_resp  in  1  memory completion.
- match, valid_out, dirty_out  in  WAYS each  per-way tag compare and state bits for the selected index; combinational, same cycle.
- plru_out  in  WAYS-1  PLRU tree bits for the selected index.
- plru_in  out  WAYS-1  new PLRU bits; plru_load  out  1  write strobe.
- data_load, tag_load, valid_load, dirty_load  out  WAYS each  one-hot array write strobes.
- valid_in, dirty_in  out  1 each  value written to the loaded way.
- write_array_sel  out  1  data source: 0 = CPU write data, 1 = pmem line.
- way_sel  out  W  output/write-back data mux select.
- pmem_address_sel  out  1  pmem address source: 0 = request address, 1 = {tag[way_sel], index}.
- index_sel  out  1  array index source: 0 = CPU address, 1 = flush_index.
- flush_index  out  S  flush set counter.

## Operation
- States: COMPARE, WRITEBACK, FILL, FLUSH_CHECK, FLUSH_WB.
- Outputs not driven by a state are 0.
- Reset: state = COMPARE, victim_q = 0, flush_index = 0, flush_way = 0. With no request, every output is 0.
- Hit in COMPARE: a hit is any way with match[w] && valid_out[w] while mem_read || mem_write is high.
  - If several ways hit, the lowest index wins.
  - Outputs: mem_resp = 1, way_sel = w, plru_load = 1, plru_in = PLRU update for w.
  - On a write also: data_load[w] = 1, write_array_sel = 0, dirty_load[w] = 1, dirty_in = 1.
- Miss in COMPARE, victim choice: the lowest-index way with valid_out = 0. If every way is valid, the victim is the tree-PLRU victim.
  - The victim is registered into victim_q on the transition out of COMPARE.
  - Victim valid and dirty → WRITEBACK; otherwise → FILL.
- PLRU tree:
  - Node 0 is the root; node i has children 2i+1 and 2i+2. Bit 0 = victim in the left subtree.
  - Victim: walk from the root following the bits.
  - Update on access to way w: each node on w's path is set to point away from w. Nodes off the path keep plru_out.
- WRITEBACK: pmem_write = 1, pmem_address_sel = 1, way_sel = victim_q. On pmem_resp → FILL.
- FILL: pmem_read = 1, pmem_address_sel = 0.
  - On pmem_resp, for victim_q: tag_load = data_load = valid_load = dirty_load = 1.
  - Also on pmem_resp: valid_in = 1, dirty_in = 0, write_array_sel = 1, plru_load = 1 with the update for victim_q. Then → COMPARE.
  - The re-lookup in COMPARE then hits and completes the access, including the write merge.
- Flush entry: flush_req is accepted only in COMPARE with no mem_read/mem_write pending. CPU requests have priority.
- Flush walk (index_sel = 1 in both flush states):
  - FLUSH_CHECK: checks way flush_way of set flush_index. If valid && dirty → FLUSH_WB; else advance.
  - FLUSH_WB: pmem_write = 1, pmem_address_sel = 1, way_sel = flush_way. On pmem_resp: dirty_load[flush_way] = 1, dirty_in = 0, then advance.
  - Advance:
    - flush_way increments.
    - When flush_way wraps from WAYS-1 to 0, flush_index increments.
    - After set SETS-1, way WAYS-1: pulse flush_done, clear both counters, → COMPARE.
- The flush leaves valid and PLRU bits unchanged. mem_resp stays 0 during the flush.

## Timing
- Read or write hit: mem_resp in the same cycle the request is seen.
- Clean miss: 1 COMPARE cycle, then FILL for N cycles (N = pmem latency including the pmem_resp cycle), then a COMPARE hit. mem_resp arrives in cycle N+2.
- Dirty miss: as a clean miss plus WRITEBACK for M cycles; mem_resp in cycle M+N+2.
- pmem_read and pmem_write are never high together. Each is held continuously until pmem_resp, and drops the cycle after.
- Flush: WAYS×SETS FLUSH_CHECK/advance cycles plus each write-back's duration. flush_done is high for exactly 1 cycle.
- Reset mid-operation (any state): the next cycle is COMPARE with pmem_* = 0, and no array load is asserted in the reset cycle. A partial pmem transaction is abandoned; array contents are untouched.
- pmem_resp outside WRITEBACK, FILL and FLUSH_WB is ignored.

## Test plan
- WAYS=4, plru_out = 3'b000, read matches valid way 2 → same-cycle mem_resp = 1, way_sel = 2, plru_load = 1, plru_in = 3'b100.
- Read miss, valid_out = 4'b1101 → no WRITEBACK. pmem_read held until pmem_resp. On pmem_resp: tag_load = 4'b0010, valid_in = 1, dirty_in = 0. Next cycle hit with mem_resp = 1.
- Write miss, all valid, plru_out = 3'b000, dirty_out = 4'b0001 → victim 0; WRITEBACK with pmem_address_sel = 1, way_sel = 0. pmem_resp at cycle 5 → FILL → COMPARE with data_load = 4'b0001, dirty_in = 1, mem_resp = 1.
- SETS=8, WAYS=4, flush_req with only set 3 way 2 dirty → exactly one pmem_write, with flush_index = 3, way_sel = 2, dirty_load = 4'b0100, dirty_in = 0. flush_done pulses once, after 32 checks plus the write-back.
- flush_req and mem_read (hit) in the same cycle → read completes first (mem_resp = 1); flush starts the next cycle.
- rst_n = 0 during WRITEBACK (pmem_write = 1) → next cycle pmem_write = 0, state COMPARE, all load strobes 0.

Source files
------------

// File: rtl/l2_cache_control_nway_if.sv
// rtl/l2_cache_control_nway_if.sv - L1/pmem/array handshake bundle for the N-way L2 controller
//
// Purpose: groups every non-clock/reset signal of l2_cache_control_nway.
// master modport: the controller view (drives responses, pmem requests, array strobes).
// slave modport : the environment view (L1 arbiter, physical memory, array datapath).
// Signals:
//   mem_read/mem_write/mem_resp      upstream request strobes and completion
//   flush_req/flush_done             whole-cache write-back flush request / finish pulse
//   pmem_read/pmem_write/pmem_resp   physical memory request and completion
//   match/valid_out/dirty_out        per-way tag compare and state bits of the selected set
//   plru_out/plru_in/plru_load       tree pseudo-LRU bits read / written
//   data_load/tag_load/valid_load/dirty_load, valid_in/dirty_in   one-hot array writes
//   write_array_sel/way_sel/pmem_address_sel/index_sel/flush_index   datapath muxes

interface l2_cache_control_nway_if #(
  parameter int WAYS = 4,
  parameter int SETS = 8
);
  localparam int W = $clog2(WAYS);
  localparam int S = $clog2(SETS);

  logic            mem_read;
  logic            mem_write;
  logic            mem_resp;
  logic            flush_req;
  logic            flush_done;
  logic            pmem_read;
  logic            pmem_write;
  logic            pmem_resp;
  logic [WAYS-1:0] match;
  logic [WAYS-1:0] valid_out;
  logic [WAYS-1:0] dirty_out;
  logic [WAYS-2:0] plru_out;
  logic [WAYS-2:0] plru_in;
  logic            plru_load;
  logic [WAYS-1:0] data_load;
  logic [WAYS-1:0] tag_load;
  logic [WAYS-1:0] valid_load;
  logic [WAYS-1:0] dirty_load;
  logic            valid_in;
  logic            dirty_in;
  logic            write_array_sel;
  logic [W-1:0]    way_sel;
  logic            pmem_address_sel;
  logic            index_sel;
  logic [S-1:0]    flush_index;

  modport master (
    input  mem_read, mem_write, flush_req, pmem_resp,
    input  match, valid_out, dirty_out, plru_out,
    output mem_resp, flush_done, pmem_read, pmem_write,
    output plru_in, plru_load, data_load, tag_load, valid_load, dirty_load,
    output valid_in, dirty_in, write_array_sel, way_sel, pmem_address_sel,
    output index_sel, flush_index
  );

  modport slave (
    output mem_read, mem_write, flush_req, pmem_resp,
    output match, valid_out, dirty_out, plru_out,
    input  mem_resp, flush_done, pmem_read, pmem_write,
    input  plru_in, plru_load, data_load, tag_load, valid_load, dirty_load,
    input  valid_in, dirty_in, write_array_sel, way_sel, pmem_address_sel,
    input  index_sel, flush_index
  );
endinterface

// File: rtl/l2_cache_control_nway.sv
// rtl/l2_cache_control_nway.sv - WAYS-way SETS-set L2 cache controller FSM with flush walker
//
// Purpose: sequences hits, write-back/fill misses and a whole-cache dirty-line
// flush for a set-associative L2 datapath with tree pseudo-LRU replacement.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    l2_cache_control_nway_if.master (requests, pmem handshake, array strobes)
// Outputs are a combinational decode of state and the same-cycle array lookup,
// which is what lets a hit answer in the cycle its request is seen.

module l2_cache_control_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic clk,
  input  logic rst_n,
  l2_cache_control_nway_if.master bus
);
  localparam int W  = $clog2(WAYS);
  localparam int S  = $clog2(SETS);
  localparam int NW = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

  typedef enum logic [2:0] {
    COMPARE,
    WRITEBACK,
    FILL,
    FLUSH_CHECK,
    FLUSH_WB
  } state_t;

  state_t       r_state;
  logic [W-1:0] r_victim;
  logic [W-1:0] r_flush_way;
  logic [S-1:0] r_flush_index;

  logic            w_req;
  logic [WAYS-1:0] w_hit_vec;
  logic            w_hit;
  logic [W-1:0]    w_hit_way;
  logic            w_any_inv;
  logic [W-1:0]    w_inv_way;
  logic [W-1:0]    w_victim;
  logic            w_victim_dirty;
  logic            w_flush_dirty;
  logic            w_flush_last;
  logic            w_flush_adv;

  // Walk root to leaf; a 0 bit means the victim lies in the left subtree.
  function automatic logic [W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [NW-1:0] node;
    logic [W-1:0]  way;
    logic          b;
    node = '0;
    way  = '0;
    for (int l = 0; l < W; l++) begin
      b      = bits[node];
      way    = way << 1;
      way[0] = b;
      node   = NW'((int'(node) << 1) + (b ? 2 : 1));
    end
    return way;
  endfunction

  // Point every node on way w's path away from w; off-path nodes keep their value.
  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] bits,
                                                  input logic [W-1:0] w);
    logic [NW-1:0]   node;
    logic [W-1:0]    tw;
    logic [WAYS-2:0] res;
    logic            b;
    node = '0;
    tw   = w;
    res  = bits;
    for (int l = 0; l < W; l++) begin
      b         = tw[W-1];
      tw        = tw << 1;
      res[node] = ~b;
      node      = NW'((int'(node) << 1) + (b ? 2 : 1));
    end
    return res;
  endfunction

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_hit_vec = bus.match & bus.valid_out;
  assign w_hit     = |w_hit_vec;
  assign w_any_inv = ~&bus.valid_out;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    w_hit_way = '0;
    w_inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit_vec[i])     w_hit_way = W'(i);
      if (!bus.valid_out[i]) w_inv_way = W'(i);
    end
  end

  assign w_victim       = w_any_inv ? w_inv_way : plru_victim(bus.plru_out);
  assign w_victim_dirty = bus.valid_out[w_victim] & bus.dirty_out[w_victim];

  assign w_flush_dirty = bus.valid_out[r_flush_way] & bus.dirty_out[r_flush_way];
  assign w_flush_last  = (r_flush_index == S'(SETS - 1)) && (r_flush_way == W'(WAYS - 1));
  assign w_flush_adv   = ((r_state == FLUSH_CHECK) && !w_flush_dirty) ||
                         ((r_state == FLUSH_WB) && bus.pmem_resp);

  assign bus.flush_index = r_flush_index;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= COMPARE;
      r_victim      <= '0;
      r_flush_way   <= '0;
      r_flush_index <= '0;
    end else begin
      case (r_state)
        COMPARE: begin
          if (w_req) begin
            if (!w_hit) begin
              r_victim <= w_victim;
              r_state  <= w_victim_dirty ? WRITEBACK : FILL;
            end
          end else if (bus.flush_req) begin
            r_state <= FLUSH_CHECK;
          end
        end
        WRITEBACK:   if (bus.pmem_resp) r_state <= FILL;
        FILL:        if (bus.pmem_resp) r_state <= COMPARE;
        FLUSH_CHECK: if (w_flush_dirty) r_state <= FLUSH_WB;
        FLUSH_WB:    ;
        default:     r_state <= COMPARE;
      endcase

      if (w_flush_adv) begin
        if (w_flush_last) begin
          r_flush_way   <= '0;
          r_flush_index <= '0;
          r_state       <= COMPARE;
        end else begin
          r_flush_way <= r_flush_way + 1'b1;
          if (r_flush_way == W'(WAYS - 1)) r_flush_index <= r_flush_index + 1'b1;
          r_state <= FLUSH_CHECK;
        end
      end
    end
  end

  // Gated by rst_n so no array strobe or pmem request escapes during the reset cycle.
  always_comb begin
    bus.mem_resp         = 1'b0;
    bus.flush_done       = 1'b0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    bus.plru_in          = '0;
    bus.plru_load        = 1'b0;
    bus.data_load        = '0;
    bus.tag_load         = '0;
    bus.valid_load       = '0;
    bus.dirty_load       = '0;
    bus.valid_in         = 1'b0;
    bus.dirty_in         = 1'b0;
    bus.write_array_sel  = 1'b0;
    bus.way_sel          = '0;
    bus.pmem_address_sel = 1'b0;
    bus.index_sel        = 1'b0;
    if (rst_n) begin
      case (r_state)
        COMPARE: begin
          if (w_req && w_hit) begin
            bus.mem_resp  = 1'b1;
            bus.way_sel   = w_hit_way;
            bus.plru_load = 1'b1;
            bus.plru_in   = plru_update(bus.plru_out, w_hit_way);
            if (bus.mem_write) begin
              bus.data_load  = WAYS'(1) << w_hit_way;
              bus.dirty_load = WAYS'(1) << w_hit_way;
              bus.dirty_in   = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          bus.pmem_write       = 1'b1;
          bus.pmem_address_sel = 1'b1;
          bus.way_sel          = r_victim;
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.tag_load        = WAYS'(1) << r_victim;
            bus.data_load       = WAYS'(1) << r_victim;
            bus.valid_load      = WAYS'(1) << r_victim;
            bus.dirty_load      = WAYS'(1) << r_victim;
            bus.valid_in        = 1'b1;
            bus.write_array_sel = 1'b1;
            bus.plru_load       = 1'b1;
            bus.plru_in         = plru_update(bus.plru_out, r_victim);
          end
        end
        FLUSH_CHECK: begin
          bus.index_sel  = 1'b1;
          bus.flush_done = !w_flush_dirty && w_flush_last;
        end
        FLUSH_WB: begin
          bus.index_sel        = 1'b1;
          bus.pmem_write       = 1'b1;
          bus.pmem_address_sel = 1'b1;
          bus.way_sel          = r_flush_way;
          if (bus.pmem_resp) begin
            bus.dirty_load = WAYS'(1) << r_flush_way;
            bus.flush_done = w_flush_last;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
